// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared constants and helpers for the instruction-fetch slice.
//               Holds the reset fetch address, the fetch FSM encodings and
//               the opcode/funct bit positions within an instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    typedef logic [31:0] word_t;

    // First fetch address after reset
    localparam word_t c_pc_reset = 32'h0000_3000;

    // Fetch FSM encodings
    localparam logic [1:0] c_st_fetch = 2'd0;  // request outstanding
    localparam logic [1:0] c_st_drain = 2'd1;  // discarding a stale response
    localparam logic [1:0] c_st_hold  = 2'd2;  // one instruction buffered

    // Instruction field positions
    localparam int c_opcode_msb = 31;
    localparam int c_opcode_lsb = 26;
    localparam int c_funct_msb  = 5;
    localparam int c_funct_lsb  = 0;

    // Clear the byte-offset bits so every fetch address is word aligned
    function automatic word_t align_word(input word_t addr);
        return addr & ~32'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundle of the fetch unit's memory, redirect and downstream
//               instruction signals.
//               master : the fetch unit (drives imem_req/imem_addr and the
//                        held instruction outputs)
//               slave  : the environment (memory, datapath, decoder)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    // instruction memory
    logic        imem_req;
    word_t       imem_addr;
    logic        imem_ack;
    word_t       imem_rdata;
    // datapath redirect
    logic        redirect_valid;
    word_t       redirect_pc;
    // downstream instruction
    logic        instr_ready;
    logic        instr_valid;
    word_t       instr;
    word_t       instr_pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    word_t       fetch_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        input  instr_ready,
        output instr_valid, instr, instr_pc, opcode, funct, fetch_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        output instr_ready,
        input  instr_valid, instr, instr_pc, opcode, funct, fetch_count
    );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pc
// Description : Program-counter register for the fetch unit, with the +4
//               sequential adder and the redirect mux. Redirect targets are
//               word aligned before use, so pc[1:0] is always zero.
// Ports       : clk, rst    - clock, asynchronous active-high reset
//               i_load      - take the redirect target (wins over i_advance)
//               i_target    - raw redirect target
//               i_advance   - step to the next sequential word
//               o_pc        - current pc
//               o_target    - aligned redirect target
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_pc
    import instr_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  word_t i_target,
    input  logic  i_advance,
    output word_t o_pc,
    output word_t o_target
);

    word_t r_pc;
    word_t w_target;

    assign w_target = align_word(i_target);

    // The +4 wraps naturally at the top of the address space
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= c_pc_reset;
        end else if (i_load) begin
            r_pc <= w_target;
        end else if (i_advance) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_pc     = r_pc;
    assign o_target = w_target;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Single-entry instruction fetch unit. Issues one memory
//               request at a time, buffers the returned word until the
//               decoder accepts it, and honours branch/jump redirects by
//               dropping stale responses and flushing the buffer.
// Ports       : clk  - clock, all state on the rising edge
//               rst  - asynchronous active-high reset
//               bus  - instr_fetch_if.master: memory request/response,
//                      redirect, held instruction, opcode/funct, fetch_count
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    logic [1:0] r_state;
    word_t      r_req_addr;
    word_t      r_instr;
    word_t      r_instr_pc;
    logic       r_instr_valid;
    word_t      r_fetch_count;

    word_t      w_pc;
    word_t      w_target;
    logic       w_advance;

    // The pc follows every redirect in any state, so once the fetch FSM
    // returns to FETCH the next request always goes to the newest target.
    assign w_advance = (r_state == c_st_fetch) && bus.imem_ack && !bus.redirect_valid;

    instr_fetch_pc u_pc (
        .clk       (clk),
        .rst       (rst),
        .i_load    (bus.redirect_valid),
        .i_target  (bus.redirect_pc),
        .i_advance (w_advance),
        .o_pc      (w_pc),
        .o_target  (w_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_fetch;
            r_req_addr    <= c_pc_reset;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_instr_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (bus.redirect_valid) begin
                        if (bus.imem_ack) begin
                            // Request already completed: drop its data and
                            // start the target fetch straight away.
                            r_req_addr <= w_target;
                        end else begin
                            // Outstanding request must still be drained;
                            // the address stays stable for the memory.
                            r_state <= c_st_drain;
                        end
                    end else if (bus.imem_ack) begin
                        r_instr       <= bus.imem_rdata;
                        r_instr_pc    <= r_req_addr;
                        r_instr_valid <= 1'b1;
                        r_state       <= c_st_hold;
                    end
                end

                c_st_drain: begin
                    // A redirect here only moves the pc; keep draining.
                    if (!bus.redirect_valid && bus.imem_ack) begin
                        r_req_addr <= w_pc;
                        r_state    <= c_st_fetch;
                    end
                end

                c_st_hold: begin
                    if (bus.redirect_valid) begin
                        // Flush without counting, even if accepted now
                        r_instr_valid <= 1'b0;
                        r_req_addr    <= w_target;
                        r_state       <= c_st_fetch;
                    end else if (bus.instr_ready) begin
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_instr_valid <= 1'b0;
                        r_req_addr    <= w_pc;
                        r_state       <= c_st_fetch;
                    end
                end

                default: begin
                    r_instr_valid <= 1'b0;
                    r_req_addr    <= w_pc;
                    r_state       <= c_st_fetch;
                end
            endcase
        end
    end

    assign bus.imem_req    = (r_state == c_st_fetch) || (r_state == c_st_drain);
    assign bus.imem_addr   = r_req_addr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.fetch_count = r_fetch_count;

    // Decoder sees zero fields whenever nothing is held
    assign bus.opcode = r_instr_valid ? r_instr[c_opcode_msb:c_opcode_lsb] : 6'd0;
    assign bus.funct  = r_instr_valid ? r_instr[c_funct_msb:c_funct_lsb]   : 6'd0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch. A memory responder
//               returns a word derived from the address; a program-order
//               model predicts the address of the next instruction the
//               decoder should see (sequential +4, or an aligned redirect
//               target) and the number consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int consumed    = 0;

    // memory responder control
    int mem_lat  = 0;
    bit mem_rand = 1'b0;

    // next instruction address expected in program order
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C08_3004;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0000_3000);
    endtask

    // Leaves the caller at a falling edge with rst just released
    task automatic do_reset(input int cycles);
        @(negedge clk);
        assert_rst();
        bus.instr_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        exp_q.delete();
        exp_q.push_back(target & 32'hFFFF_FFFC);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!bus.instr_valid && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        check(name, 32'(bus.instr_valid), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Memory responder: acks after a per-request latency
    // ------------------------------------------------------------------
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || !bus.imem_req) begin
                bus.imem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (cnt == 0) cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                if (cnt >= cur_lat) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    cnt = 0;
                end else begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = $urandom;
                    cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard: samples the values the next rising edge sees
    // ------------------------------------------------------------------
    initial begin
        bit          pv;
        logic        p_req, p_ack, p_valid, p_redir, p_ready;
        logic [31:0] p_addr, p_instr, p_ipc;
        logic [31:0] e_pc, e_word;
        int          model_cnt;
        pv = 1'b0;
        model_cnt = 0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                model_cnt = 0;
                pv = 1'b0;
            end else begin
                check("req_is_not_valid", 32'(bus.imem_req), 32'(!bus.instr_valid));
                if (bus.imem_req)
                    check("addr_aligned", 32'(bus.imem_addr[1:0]), 32'd0);
                check("fetch_count", bus.fetch_count, 32'(model_cnt));

                if (bus.instr_valid && !bus.redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        check("exp_queue_empty", 32'd0, 32'd1);
                    end else begin
                        e_pc   = exp_q[0];
                        e_word = mem_word(e_pc);
                        check("instr_pc", bus.instr_pc, e_pc);
                        check("instr", bus.instr, e_word);
                        check("opcode", 32'(bus.opcode), 32'(e_word[31:26]));
                        check("funct", 32'(bus.funct), 32'(e_word[5:0]));
                    end
                end else if (!bus.instr_valid) begin
                    check("opcode_idle", 32'(bus.opcode), 32'd0);
                    check("funct_idle", 32'(bus.funct), 32'd0);
                end

                if (pv && p_req && !p_ack) begin
                    check("req_held", 32'(bus.imem_req), 32'd1);
                    check("addr_stable", bus.imem_addr, p_addr);
                end

                if (pv && p_valid && !p_redir && !p_ready) begin
                    check("hold_valid", 32'(bus.instr_valid), 32'd1);
                    check("hold_pc", bus.instr_pc, p_ipc);
                    check("hold_instr", bus.instr, p_instr);
                end

                // instruction consumed at the coming edge
                if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid && exp_q.size() > 0) begin
                    e_pc = exp_q.pop_front();
                    exp_q.push_back(e_pc + 32'd4);
                    model_cnt++;
                    consumed++;
                end

                p_req   = bus.imem_req;
                p_ack   = bus.imem_ack;
                p_valid = bus.instr_valid;
                p_redir = bus.redirect_valid;
                p_ready = bus.instr_ready;
                p_addr  = bus.imem_addr;
                p_instr = bus.instr;
                p_ipc   = bus.instr_pc;
                pv      = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int start_consumed;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.instr_ready    = 1'b0;
        exp_q.push_back(32'h0000_3000);

        // Zero-wait memory, reset values and two-cycle throughput
        mem_rand = 1'b0;
        mem_lat  = 0;
        do_reset(2);
        bus.instr_ready = 1'b1;
        #2;
        check("s1_rst_req", 32'(bus.imem_req), 32'd1);
        check("s1_rst_addr", bus.imem_addr, 32'h0000_3000);
        check("s1_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("s1_rst_instr", bus.instr, 32'd0);
        check("s1_rst_ipc", bus.instr_pc, 32'd0);
        check("s1_rst_count", bus.fetch_count, 32'd0);
        @(negedge clk); #2;
        check("s1_valid", 32'(bus.instr_valid), 32'd1);
        check("s1_ipc", bus.instr_pc, 32'h0000_3000);
        check("s1_instr", bus.instr, 32'h8C08_0004);
        check("s1_opcode", 32'(bus.opcode), 32'h23);
        check("s1_funct", 32'(bus.funct), 32'h04);
        @(negedge clk); #2;
        check("s1_addr2", bus.imem_addr, 32'h0000_3004);
        check("s1_count1", bus.fetch_count, 32'd1);
        @(negedge clk); #2;
        check("s1_tput_valid", 32'(bus.instr_valid), 32'd1);
        check("s1_tput_ipc", bus.instr_pc, 32'h0000_3004);
        @(negedge clk); #2;
        check("s1_addr3", bus.imem_addr, 32'h0000_3008);
        check("s1_count2", bus.fetch_count, 32'd2);

        // Ack delayed three cycles
        mem_lat = 3;
        do_reset(2);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("s2_addr_stable", bus.imem_addr, 32'h0000_3000);
            check("s2_req", 32'(bus.imem_req), 32'd1);
            check("s2_not_valid", 32'(bus.instr_valid), 32'd0);
            @(negedge clk);
        end
        #2;
        check("s2_valid", 32'(bus.instr_valid), 32'd1);
        check("s2_ipc", bus.instr_pc, 32'h0000_3000);

        // Redirect while waiting, stale ack two cycles later
        mem_lat = 2;
        do_reset(2);
        bus.instr_ready = 1'b1;
        redirect(32'h0000_3040);
        #2;
        check("s3_addr0", bus.imem_addr, 32'h0000_3000);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        check("s3_drain_valid", 32'(bus.instr_valid), 32'd0);
        check("s3_drain_addr", bus.imem_addr, 32'h0000_3000);
        @(negedge clk); #2;
        check("s3_stale_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk); #2;
        check("s3_new_addr", bus.imem_addr, 32'h0000_3040);
        check("s3_new_valid", 32'(bus.instr_valid), 32'd0);
        wait_valid("s3_wait", 10);
        check("s3_ipc", bus.instr_pc, 32'h0000_3040);

        // Stall in HOLD, then redirect while ready
        mem_lat = 0;
        do_reset(2);
        bus.instr_ready = 1'b0;
        #2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            check("s4_hold_valid", 32'(bus.instr_valid), 32'd1);
            check("s4_hold_ipc", bus.instr_pc, 32'h0000_3000);
            check("s4_hold_req", 32'(bus.imem_req), 32'd0);
        end
        @(negedge clk);
        redirect(32'h0000_3100);
        bus.instr_ready = 1'b1;
        #2;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        check("s4_flushed", 32'(bus.instr_valid), 32'd0);
        check("s4_count", bus.fetch_count, 32'd0);
        check("s4_addr", bus.imem_addr, 32'h0000_3100);
        wait_valid("s4_wait", 10);
        check("s4_ipc", bus.instr_pc, 32'h0000_3100);
        @(negedge clk); #2;
        check("s4_count1", bus.fetch_count, 32'd1);

        // Unaligned redirect at the top of memory, coinciding with an ack
        do_reset(2);
        bus.instr_ready = 1'b1;
        redirect(32'hFFFF_FFFE);
        #2;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #2;
        check("s5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        check("s5_no_valid", 32'(bus.instr_valid), 32'd0);
        @(negedge clk); #2;
        check("s5_ipc", bus.instr_pc, 32'hFFFF_FFFC);
        @(negedge clk); #2;
        check("s5_wrap_addr", bus.imem_addr, 32'h0000_0000);
        check("s5_count", bus.fetch_count, 32'd1);

        // Reset while waiting for an ack, and while holding
        mem_lat = 5;
        do_reset(2);
        bus.instr_ready = 1'b1;
        #2;
        wait_valid("s6_first", 12);
        @(negedge clk); #2;
        check("s6_wait_addr", bus.imem_addr, 32'h0000_3004);
        @(negedge clk);
        assert_rst();
        #2;
        check("s6_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("s6_rst_addr", bus.imem_addr, 32'h0000_3000);
        check("s6_rst_count", bus.fetch_count, 32'd0);
        mem_lat = 0;
        @(negedge clk);
        rst = 1'b0;
        bus.instr_ready = 1'b0;
        #2;
        check("s6_restart_addr", bus.imem_addr, 32'h0000_3000);
        wait_valid("s6_restart", 10);
        check("s6_restart_ipc", bus.instr_pc, 32'h0000_3000);
        @(negedge clk);
        assert_rst();
        #2;
        check("s6_hold_rst_valid", 32'(bus.instr_valid), 32'd0);

        // Randomized traffic
        mem_rand = 1'b1;
        do_reset(2);
        start_consumed = consumed;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                assert_rst();
            end
            if (!rst) begin
                bus.instr_ready = ($urandom_range(0, 99) < 70);
                if ($urandom_range(0, 99) < 6) begin
                    case ($urandom_range(0, 3))
                        0: redirect($urandom);
                        1: redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                        2: redirect(32'h0000_3000 + 32'($urandom_range(0, 255) * 4));
                        default: redirect($urandom);
                    endcase
                end else begin
                    bus.redirect_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        #4;
        check("rand_progress", 32'(consumed - start_consumed >= 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
